// File: rtl/spi_bus_arbiter_if.sv
// Purpose : bundles the two client request/byte channels and the spi_master side of spi_bus_arbiter.
// Ports   : c0_*/c1_* client req/start/tx in, gnt/done/rx out; m_start/m_tx to spi_master, m_rx/m_done back; arb_err.
// Modports: master = arbiter view, slave = clients plus spi_master view.
interface spi_bus_arbiter_if;
   logic       c0_req;
   logic       c1_req;
   logic       c0_start;
   logic       c1_start;
   logic [7:0] c0_tx;
   logic [7:0] c1_tx;
   logic       c0_gnt;
   logic       c1_gnt;
   logic       c0_done;
   logic       c1_done;
   logic [7:0] c0_rx;
   logic [7:0] c1_rx;
   logic       m_start;
   logic [7:0] m_tx;
   logic [7:0] m_rx;
   logic       m_done;
   logic       arb_err;

   modport master (
      input  c0_req, c1_req, c0_start, c1_start, c0_tx, c1_tx, m_rx, m_done,
      output c0_gnt, c1_gnt, c0_done, c1_done, c0_rx, c1_rx, m_start, m_tx, arb_err
   );

   modport slave (
      output c0_req, c1_req, c0_start, c1_start, c0_tx, c1_tx, m_rx, m_done,
      input  c0_gnt, c1_gnt, c0_done, c1_done, c0_rx, c1_rx, m_start, m_tx, arb_err
   );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Purpose : shares one spi_master between two clients; a client owns the master for a whole multi-byte transaction.
// Latency : grant 1 cycle after req seen in IDLE; m_start 1 cycle after owner start; cN_done 1 cycle after m_done.
// Backpressure: starts from non-owners or while busy are dropped; one dead cycle between ownerships.
// Ports   : clk, rst (sync, active-high); bus = spi_bus_arbiter_if.master (client channels + spi_master side).
// Option  : define SPI_ARB_TIMEOUT_EN to abort a byte after TIMEOUT_CYCLES XFER cycles (cN_rx=8'hFF, arb_err pulse).
module spi_bus_arbiter #(
   parameter int unsigned TIMEOUT_CYCLES = 1024
) (
   input  logic                  clk,
   input  logic                  rst,
   spi_bus_arbiter_if.master     bus
);

   typedef enum logic [1:0] {S_IDLE, S_OWN, S_XFER, S_RELEASE} state_t;

   if (TIMEOUT_CYCLES < 1) begin : g_param_check
      $error("TIMEOUT_CYCLES must be at least 1");
   end

   state_t     r_state;
   logic       r_owner;
   logic       r_last_owner;
   logic       r_gnt0, r_gnt1;
   logic       r_done0, r_done1;
   logic [7:0] r_rx0, r_rx1;
   logic       r_m_start;
   logic [7:0] r_m_tx;

   logic       w_own_req;
   logic       w_own_start;
   logic [7:0] w_own_tx;
   logic       w_pick;
   logic       w_xfer_end;
   logic [7:0] w_xfer_dat;

   assign w_own_req   = r_owner ? bus.c1_req   : bus.c0_req;
   assign w_own_start = r_owner ? bus.c1_start : bus.c0_start;
   assign w_own_tx    = r_owner ? bus.c1_tx    : bus.c0_tx;
   // Tie goes to whoever did not own last; otherwise the sole requester.
   assign w_pick      = (bus.c0_req && bus.c1_req) ? ~r_last_owner : bus.c1_req;

`ifdef SPI_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             r_arb_err;
   logic             w_timeout;

   // A real m_done always beats a simultaneous timeout.
   always_comb begin
      w_timeout  = 1'b0;
      w_xfer_end = bus.m_done;
      w_xfer_dat = bus.m_rx;
      if (!bus.m_done && (r_cnt == CNT_LAST)) begin
         w_timeout  = 1'b1;
         w_xfer_end = 1'b1;
         w_xfer_dat = 8'hFF;
      end
   end

   assign bus.arb_err = r_arb_err;
`else
   assign w_xfer_end  = bus.m_done;
   assign w_xfer_dat  = bus.m_rx;
   assign bus.arb_err = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state      <= S_IDLE;
         r_owner      <= 1'b0;
         r_last_owner <= 1'b1;
         r_gnt0       <= 1'b0;
         r_gnt1       <= 1'b0;
         r_done0      <= 1'b0;
         r_done1      <= 1'b0;
         r_rx0        <= 8'h00;
         r_rx1        <= 8'h00;
         r_m_start    <= 1'b0;
         r_m_tx       <= 8'h00;
`ifdef SPI_ARB_TIMEOUT_EN
         r_cnt        <= '0;
         r_arb_err    <= 1'b0;
`endif
      end else begin
         r_m_start <= 1'b0;
         r_done0   <= 1'b0;
         r_done1   <= 1'b0;
`ifdef SPI_ARB_TIMEOUT_EN
         r_arb_err <= 1'b0;
`endif
         case (r_state)
            S_IDLE: begin
               if (bus.c0_req || bus.c1_req) begin
                  r_owner <= w_pick;
                  r_gnt0  <= ~w_pick;
                  r_gnt1  <= w_pick;
                  r_state <= S_OWN;
               end
            end
            S_OWN: begin
               // Release is only evaluated here, so a req drop mid-byte waits for the byte to finish.
               if (!w_own_req) begin
                  r_gnt0       <= 1'b0;
                  r_gnt1       <= 1'b0;
                  r_last_owner <= r_owner;
                  r_state      <= S_RELEASE;
               end else if (w_own_start) begin
                  r_m_tx    <= w_own_tx;
                  r_m_start <= 1'b1;
                  r_state   <= S_XFER;
`ifdef SPI_ARB_TIMEOUT_EN
                  r_cnt     <= '0;
`endif
               end
            end
            S_XFER: begin
               if (w_xfer_end) begin
                  if (r_owner) begin
                     r_rx1   <= w_xfer_dat;
                     r_done1 <= 1'b1;
                  end else begin
                     r_rx0   <= w_xfer_dat;
                     r_done0 <= 1'b1;
                  end
                  r_state <= S_OWN;
`ifdef SPI_ARB_TIMEOUT_EN
                  r_arb_err <= w_timeout;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
`endif
               end
            end
            S_RELEASE: r_state <= S_IDLE;
            default:   r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.c0_gnt  = r_gnt0;
   assign bus.c1_gnt  = r_gnt1;
   assign bus.c0_done = r_done0;
   assign bus.c1_done = r_done1;
   assign bus.c0_rx   = r_rx0;
   assign bus.c1_rx   = r_rx1;
   assign bus.m_start = r_m_start;
   assign bus.m_tx    = r_m_tx;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Purpose : self-checking bench for spi_bus_arbiter: directed scenarios with literal expectations plus random traffic.
// Model   : ownership tracked as "who owns / is a byte in flight / dead cycle pending"; outputs predicted per edge.
// Compare : every negedge all DUT outputs are checked against the model; literal checks sit 2ns after posedge.
module tb_spi_bus_arbiter;
   localparam int TO = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   spi_bus_arbiter_if u_if ();

   spi_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
      .clk (clk),
      .rst (rst),
      .bus (u_if)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk1(input string nm, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk8(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   // ---------------- behavioural model ----------------
   bit         has_own = 1'b0;   // some client currently holds the bus
   bit         oid     = 1'b0;   // which client
   bit         busy    = 1'b0;   // byte in flight
   bit         cool    = 1'b0;   // mandatory dead cycle after a release
   bit         last    = 1'b1;
   int         xcnt    = 0;
   bit [1:0]   e_gnt   = 2'b00;
   bit [1:0]   e_done  = 2'b00;
   logic [7:0] e_rx [2] = '{8'h00, 8'h00};
   bit         e_ms    = 1'b0;
   logic [7:0] e_mtx   = 8'h00;
   bit         e_err   = 1'b0;

   always @(posedge clk) begin : model
      logic [1:0] req;
      logic [1:0] st;
      logic [7:0] tx [2];
      logic       fin;
      logic [7:0] fv;
      req    = {u_if.c1_req, u_if.c0_req};
      st     = {u_if.c1_start, u_if.c0_start};
      tx[0]  = u_if.c0_tx;
      tx[1]  = u_if.c1_tx;
      e_done = 2'b00;
      e_ms   = 1'b0;
      e_err  = 1'b0;
      fin    = 1'b0;
      fv     = 8'h00;
      if (rst) begin
         has_own = 1'b0; busy = 1'b0; cool = 1'b0; last = 1'b1; xcnt = 0;
         e_gnt = 2'b00; e_rx[0] = 8'h00; e_rx[1] = 8'h00; e_mtx = 8'h00;
      end else if (cool) begin
         cool = 1'b0;
      end else if (!has_own) begin
         if (req != 2'b00) begin
            has_own    = 1'b1;
            oid        = (req == 2'b11) ? ~last : req[1];
            e_gnt[oid] = 1'b1;
         end
      end else if (busy) begin
         xcnt++;
         if (u_if.m_done) begin
            fin = 1'b1; fv = u_if.m_rx;
         end
`ifdef SPI_ARB_TIMEOUT_EN
         else if (xcnt == TO) begin
            fin = 1'b1; fv = 8'hFF; e_err = 1'b1;
         end
`endif
         if (fin) begin
            e_done[oid] = 1'b1;
            e_rx[oid]   = fv;
            busy        = 1'b0;
         end
      end else if (!req[oid]) begin
         e_gnt[oid] = 1'b0;
         last       = oid;
         has_own    = 1'b0;
         cool       = 1'b1;
      end else if (st[oid]) begin
         busy  = 1'b1;
         xcnt  = 0;
         e_ms  = 1'b1;
         e_mtx = tx[oid];
      end
   end

   bit cmp_en = 1'b0;

   always @(negedge clk) begin
      if (cmp_en) begin
         chk1("c0_gnt",  u_if.c0_gnt,  e_gnt[0]);
         chk1("c1_gnt",  u_if.c1_gnt,  e_gnt[1]);
         chk1("c0_done", u_if.c0_done, e_done[0]);
         chk1("c1_done", u_if.c1_done, e_done[1]);
         chk8("c0_rx",   u_if.c0_rx,   e_rx[0]);
         chk8("c1_rx",   u_if.c1_rx,   e_rx[1]);
         chk1("m_start", u_if.m_start, e_ms);
         chk8("m_tx",    u_if.m_tx,    e_mtx);
         chk1("arb_err", u_if.arb_err, e_err);
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      rst = 1'b1;
      u_if.c0_req = 1'b0; u_if.c1_req = 1'b0;
      u_if.c0_start = 1'b0; u_if.c1_start = 1'b0;
      u_if.c0_tx = 8'h00; u_if.c1_tx = 8'h00;
      u_if.m_done = 1'b0; u_if.m_rx = 8'h00;
      cyc(2);
      cmp_en = 1'b1;
      chk1("rst_c0_gnt", u_if.c0_gnt, 1'b0);
      chk1("rst_c1_gnt", u_if.c1_gnt, 1'b0);
      chk8("rst_c0_rx",  u_if.c0_rx,  8'h00);
      chk8("rst_m_tx",   u_if.m_tx,   8'h00);
      chk1("rst_arb_err", u_if.arb_err, 1'b0);
      rst = 1'b0;

      // single client byte
      u_if.c0_req = 1'b1;
      cyc(1);
      chk1("t1_gnt0", u_if.c0_gnt, 1'b1);
      chk1("t1_gnt1", u_if.c1_gnt, 1'b0);
      u_if.c0_start = 1'b1; u_if.c0_tx = 8'h0F;
      cyc(1);
      u_if.c0_start = 1'b0;
      chk1("t1_mstart", u_if.m_start, 1'b1);
      chk8("t1_mtx", u_if.m_tx, 8'h0F);
      cyc(1);
      chk1("t1_mstart_once", u_if.m_start, 1'b0);
      u_if.m_done = 1'b1; u_if.m_rx = 8'h91;
      cyc(1);
      u_if.m_done = 1'b0;
      chk1("t1_done", u_if.c0_done, 1'b1);
      chk8("t1_rx", u_if.c0_rx, 8'h91);
      chk1("t1_c1_done", u_if.c1_done, 1'b0);
      cyc(1);
      chk1("t1_done_pulse", u_if.c0_done, 1'b0);

      // req drop mid-byte holds the grant
      u_if.c0_start = 1'b1; u_if.c0_tx = 8'h55;
      cyc(1);
      u_if.c0_start = 1'b0;
      u_if.c0_req = 1'b0;
      cyc(3);
      chk1("t4_gnt_hold", u_if.c0_gnt, 1'b1);
      u_if.m_done = 1'b1; u_if.m_rx = 8'h3C;
      cyc(1);
      u_if.m_done = 1'b0;
      chk1("t4_done", u_if.c0_done, 1'b1);
      chk8("t4_rx", u_if.c0_rx, 8'h3C);
      chk1("t4_gnt_at_done", u_if.c0_gnt, 1'b1);
      cyc(1);
      chk1("t4_released", u_if.c0_gnt, 0);
      cyc(1);

      // tie after reset, non-owner start, alternation
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      u_if.c0_req = 1'b1; u_if.c1_req = 1'b1;
      cyc(1);
      chk1("t2_tie_gnt0", u_if.c0_gnt, 1'b1);
      chk1("t2_tie_gnt1", u_if.c1_gnt, 1'b0);
      u_if.c1_start = 1'b1; u_if.c1_tx = 8'hAA;
      cyc(1);
      u_if.c1_start = 1'b0;
      chk1("t3_no_mstart", u_if.m_start, 1'b0);
      cyc(2);
      chk1("t3_no_c1_done", u_if.c1_done, 1'b0);
      u_if.c0_req = 1'b0;
      cyc(1);
      chk1("t2_rel_gnt0", u_if.c0_gnt, 1'b0);
      chk1("t2_rel_gnt1", u_if.c1_gnt, 1'b0);
      cyc(1);
      chk1("t2_dead_gnt1", u_if.c1_gnt, 1'b0);
      cyc(1);
      chk1("t2_gnt1", u_if.c1_gnt, 1'b1);
      u_if.c1_req = 1'b0;
      cyc(1);
      chk1("t2_rel1", u_if.c1_gnt, 1'b0);
      u_if.c0_req = 1'b1; u_if.c1_req = 1'b1;
      cyc(2);
      chk1("t2_tie2_gnt0", u_if.c0_gnt, 1'b1);
      chk1("t2_tie2_gnt1", u_if.c1_gnt, 1'b0);

      // reset mid-byte, then a late m_done
      u_if.c1_req = 1'b0;
      u_if.c0_start = 1'b1; u_if.c0_tx = 8'h77;
      cyc(1);
      u_if.c0_start = 1'b0;
      chk1("t5_mstart", u_if.m_start, 1'b1);
      cyc(1);
      u_if.c0_req = 1'b0;
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      u_if.m_done = 1'b1; u_if.m_rx = 8'h12;
      cyc(1);
      u_if.m_done = 1'b0;
      chk1("t5_done", u_if.c0_done, 1'b0);
      chk1("t5_gnt", u_if.c0_gnt, 1'b0);
      chk8("t5_rx", u_if.c0_rx, 8'h00);
      chk8("t5_mtx", u_if.m_tx, 8'h00);
      chk1("t5_mstart", u_if.m_start, 1'b0);

      // byte with no m_done
      u_if.c0_req = 1'b1;
      cyc(1);
      u_if.c0_start = 1'b1; u_if.c0_tx = 8'hC3;
      cyc(1);
      u_if.c0_start = 1'b0;
      cyc(TO - 1);
      chk1("t6_no_done_yet", u_if.c0_done, 1'b0);
      cyc(1);
`ifdef SPI_ARB_TIMEOUT_EN
      chk1("t6_to_done", u_if.c0_done, 1'b1);
      chk8("t6_to_rx", u_if.c0_rx, 8'hFF);
      chk1("t6_to_err", u_if.arb_err, 1'b1);
      chk1("t6_to_gnt", u_if.c0_gnt, 1'b1);
      cyc(1);
      chk1("t6_err_pulse", u_if.arb_err, 1'b0);
      u_if.c0_start = 1'b1; u_if.c0_tx = 8'h5A;
      cyc(1);
      u_if.c0_start = 1'b0;
      chk1("t6_own_again", u_if.m_start, 1'b1);
      chk8("t6_own_mtx", u_if.m_tx, 8'h5A);
`else
      chk1("t6_wait_done", u_if.c0_done, 1'b0);
      chk1("t6_wait_err", u_if.arb_err, 1'b0);
      cyc(20);
      chk1("t6_still_waiting", u_if.c0_done, 1'b0);
      chk1("t6_gnt", u_if.c0_gnt, 1'b1);
`endif
      u_if.m_done = 1'b1; u_if.m_rx = 8'h66;
      cyc(1);
      u_if.m_done = 1'b0;
      chk1("t6_late_done", u_if.c0_done, 1'b1);
      chk8("t6_late_rx", u_if.c0_rx, 8'h66);
      u_if.c0_req = 1'b0;
      cyc(3);

      // random traffic against the model
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(99) < 6) u_if.c0_req = ~u_if.c0_req;
         if ($urandom_range(99) < 6) u_if.c1_req = ~u_if.c1_req;
         u_if.c0_start = ($urandom_range(99) < 30);
         u_if.c1_start = ($urandom_range(99) < 30);
         u_if.c0_tx    = 8'($urandom);
         u_if.c1_tx    = 8'($urandom);
         u_if.m_done   = ($urandom_range(99) < 15);
         u_if.m_rx     = 8'($urandom);
         rst           = ($urandom_range(999) < 4);
         cyc(1);
      end
      rst = 1'b0;
      u_if.c0_start = 1'b0; u_if.c1_start = 1'b0; u_if.m_done = 1'b0;
      cyc(2);
      cmp_en = 1'b0;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/spi_bus_arbiter.md
SPI_BUS_ARBITER -- requirements
Module: spi_bus_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1024: cycles to wait for m_done before aborting a byte; used only with SPI_ARB_TIMEOUT_EN.
REQ-002 SHALL have port clk  input  1: clock; all logic on the rising edge.
REQ-003 SHALL have port rst  input  1: reset, synchronous, active-high.
REQ-004 SHALL have ports c0_req, c1_req  input  1 each: client holds high for the whole multi-byte transaction.
REQ-005 SHALL have ports c0_start, c1_start  input  1 each: one-cycle pulse requesting a byte transfer.
REQ-006 SHALL have ports c0_tx, c1_tx  input  8 each: byte to send, sampled with the start pulse.
REQ-007 SHALL have ports c0_gnt, c1_gnt  output  1 each: client owns the SPI master.
REQ-008 SHALL have ports c0_done, c1_done  output  1 each: one-cycle pulse when the client's byte completes.
REQ-009 SHALL have ports c0_rx, c1_rx  output  8 each: received byte, valid with done.
REQ-010 SHALL have port m_start  output  1: one-cycle start pulse to spi_master.
REQ-011 SHALL have port m_tx  output  8: byte to spi_master data_in.
REQ-012 SHALL have ports m_rx  input  8 and m_done  input  1: spi_master data_out and done.
REQ-013 SHALL have port arb_err  output  1: one-cycle timeout-abort pulse.

Function
REQ-014 SHALL implement states IDLE, OWN, XFER, RELEASE, plus a 1-bit owner register and a 1-bit last_owner register.
REQ-015 IDLE: one req high -> grant that client; both high -> grant the client != last_owner; go to OWN next cycle.
REQ-016 Grant SHALL be registered: cN_gnt high exactly one cycle after the cycle in which req is sampled in IDLE.
REQ-017 OWN: owner start pulse -> latch tx into m_tx, assert m_start for exactly one cycle, enter XFER.
REQ-018 Start pulses from the non-owner, or from any client while in XFER/RELEASE/IDLE, SHALL be ignored with no queueing.
REQ-019 XFER: on m_done, register m_rx to owner's cN_rx, pulse owner's cN_done one cycle after m_done, return to OWN.
REQ-020 Non-owner cN_done SHALL stay 0; non-owner cN_rx SHALL hold its last value.
REQ-021 OWN with owner req low -> RELEASE: drop gnt, set last_owner = owner; RELEASE -> IDLE unconditionally (one dead cycle minimum between ownerships).
REQ-022 Owner req dropping during XFER SHALL NOT release the grant; release is evaluated in OWN after the byte completes.
REQ-023 m_done outside XFER SHALL be ignored.
REQ-024 At most one gnt SHALL be high in any cycle; m_start never asserts without a gnt.

Reset
REQ-025 On rst: state IDLE, all gnt/done/m_start/arb_err 0, m_tx and cN_rx 8'h00, last_owner 1 (client 0 wins the first tie).
REQ-026 Reset mid-XFER SHALL discard the in-flight byte; a late m_done after reset is ignored per REQ-023.

Configuration
REQ-027 With SPI_ARB_TIMEOUT_EN defined: counter clears on XFER entry and increments each XFER cycle; on reaching TIMEOUT_CYCLES without m_done -> owner cN_done pulse with cN_rx = 8'hFF, arb_err one-cycle pulse, return to OWN.
REQ-028 Without SPI_ARB_TIMEOUT_EN: no counter, XFER waits indefinitely, arb_err tied 0.

Verification
REQ-029 Reset then c0_req alone, c0_start with c0_tx=8'h0F, m_done with m_rx=8'h91 -> c0_gnt, one m_start with m_tx=8'h0F, c0_done with c0_rx=8'h91.
REQ-030 c0_req and c1_req rise same cycle after reset -> c0 granted; c0 releases -> RELEASE, IDLE, then c1_gnt; next tie -> c0.
REQ-031 c1_start pulsed while c0 owns -> no m_start, c1_done stays 0.
REQ-032 c0_req drops mid-XFER -> c0_gnt held until m_done, c0_done pulses, then released.
REQ-033 rst mid-XFER, then m_done -> no done pulse, all outputs at reset values.
REQ-034 SPI_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=16, m_done never asserted -> after 16 XFER cycles c0_done with c0_rx=8'hFF, arb_err pulse, state OWN.
